// File: rtl/i2c_sample_sequencer_if.sv
// Register-level handshake between the sample sequencer and a byte-wide
// I2C controller; the sequencer is the master side.
interface i2c_sample_sequencer_if;
    logic       i2c_enable;
    logic       i2c_rw;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data_in;
    logic       i2c_ready;
    logic [7:0] i2c_data_out;

    modport master (
        output i2c_enable, i2c_rw, i2c_addr, i2c_data_in,
        input  i2c_ready, i2c_data_out
    );

    modport slave (
        input  i2c_enable, i2c_rw, i2c_addr, i2c_data_in,
        output i2c_ready, i2c_data_out
    );
endinterface

// File: rtl/i2c_sample_sequencer.sv
// Reads NBYTES consecutive device registers through an I2C controller,
// on demand or periodically, and publishes them as one atomic sample.
module i2c_sample_sequencer #(
    parameter logic [6:0]  DEV_ADDR  = 7'h1D,
    parameter logic [7:0]  REG_START = 8'h01,
    parameter int unsigned NBYTES    = 6,
    parameter int unsigned PERIOD    = 100000,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    auto_en,
    i2c_sample_sequencer_if.master  bus,
    output logic [8*NBYTES-1:0]     sample_data,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    error,
    output logic                    overrun
);

    localparam int unsigned PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, NEXT, DONE, ERR
    } state_t;

    state_t               state_q;
    logic [2:0]           idx_q;
    logic [TW-1:0]        phase_q;
    logic [PW-1:0]        per_q;
    logic [8*NBYTES-1:0]  shadow_q;
    logic [8*NBYTES-1:0]  sample_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 error_q;
    logic                 ovr_q;
    logic                 en_q;
    logic                 rw_q;
    logic [7:0]           din_q;

    logic tick_d;
    logic trig_d;
    logic tmo_d;

    assign tick_d = auto_en && (per_q == PW'(PERIOD - 1));
    assign trig_d = start || tick_d;
    assign tmo_d  = (phase_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= '0;
            per_q    <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            ovr_q    <= 1'b0;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            valid_q <= 1'b0;

            if (!auto_en || per_q == PW'(PERIOD - 1)) begin
                per_q <= '0;
            end else begin
                per_q <= per_q + PW'(1);
            end

            if (trig_d && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (trig_d) begin
                        idx_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        rw_q    <= 1'b0;
                        din_q   <= REG_START;
                        phase_q <= '0;
                        state_q <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!bus.i2c_ready) begin
                        en_q    <= 1'b0;
                        phase_q <= '0;
                        state_q <= WR_WAIT;
                    end else if (tmo_d) begin
                        en_q    <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        phase_q <= phase_q + TW'(1);
                    end
                end
                WR_WAIT: begin
                    if (bus.i2c_ready) begin
                        en_q    <= 1'b1;
                        rw_q    <= 1'b1;
                        phase_q <= '0;
                        state_q <= RD_REQ;
                    end else if (tmo_d) begin
                        error_q <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        phase_q <= phase_q + TW'(1);
                    end
                end
                RD_REQ: begin
                    if (!bus.i2c_ready) begin
                        en_q    <= 1'b0;
                        phase_q <= '0;
                        state_q <= RD_WAIT;
                    end else if (tmo_d) begin
                        en_q    <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        phase_q <= phase_q + TW'(1);
                    end
                end
                RD_WAIT: begin
                    if (bus.i2c_ready) begin
                        shadow_q[8*idx_q +: 8] <= bus.i2c_data_out;
                        state_q <= NEXT;
                    end else if (tmo_d) begin
                        error_q <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        phase_q <= phase_q + TW'(1);
                    end
                end
                NEXT: begin
                    if (idx_q == 3'(NBYTES - 1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        en_q    <= 1'b1;
                        rw_q    <= 1'b0;
                        din_q   <= REG_START + 8'(idx_q) + 8'd1;
                        phase_q <= '0;
                        state_q <= WR_REQ;
                    end
                end
                DONE: begin
                    // Only a complete shadow is ever published.
                    sample_q <= shadow_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i2c_enable  = en_q;
    assign bus.i2c_rw      = rw_q;
    assign bus.i2c_addr    = DEV_ADDR;
    assign bus.i2c_data_in = din_q;
    assign sample_data     = sample_q;
    assign sample_valid    = valid_q;
    assign busy            = busy_q;
    assign error           = error_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_i2c_sample_sequencer.sv
// Randomized bench: two sequencer configurations against a latency-
// programmable controller model and a transaction-level expectation.
module tb_i2c_sample_sequencer;

    localparam int TO  = 50;
    localparam int PER = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic auto0 = 1'b0, auto1 = 1'b0;

    i2c_sample_sequencer_if bus0 ();
    i2c_sample_sequencer_if bus1 ();

    logic [47:0] sd0;
    logic [23:0] sd1;
    logic sv0, sv1, busy0, busy1, err0, err1, ovr0, ovr1;

    i2c_sample_sequencer #(
        .REG_START(8'h01), .NBYTES(6), .PERIOD(PER), .TIMEOUT(TO)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .auto_en(auto0),
        .bus(bus0), .sample_data(sd0), .sample_valid(sv0),
        .busy(busy0), .error(err0), .overrun(ovr0)
    );

    i2c_sample_sequencer #(
        .REG_START(8'hFE), .NBYTES(3), .PERIOD(PER), .TIMEOUT(TO)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .auto_en(auto1),
        .bus(bus1), .sample_data(sd1), .sample_valid(sv1),
        .busy(busy1), .error(err1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    // controller model: accepts a request while ready, stays busy m_lat cycles
    logic [1:0]      m_rdy;
    logic [1:0][7:0] m_dout;
    logic [1:0][7:0] m_nxt;
    logic [1:0]      m_rd;
    int              m_cnt [2];
    int              m_lat [2];
    logic [1:0]      m_stuck;
    logic [8:0]      log_q [$];
    logic [7:0]      ret_q [$];

    wire [1:0]      en_w  = {bus1.i2c_enable, bus0.i2c_enable};
    wire [1:0]      rw_w  = {bus1.i2c_rw, bus0.i2c_rw};
    wire [1:0][7:0] din_w = {bus1.i2c_data_in, bus0.i2c_data_in};

    assign bus0.i2c_ready    = m_rdy[0];
    assign bus1.i2c_ready    = m_rdy[1];
    assign bus0.i2c_data_out = m_dout[0];
    assign bus1.i2c_data_out = m_dout[1];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_rdy[g] <= 1'b1;
                m_cnt[g] <= 0;
            end else if (m_cnt[g] != 0) begin
                if (m_cnt[g] == 1) begin
                    m_rdy[g] <= 1'b1;
                    if (m_rd[g]) begin
                        m_dout[g] <= m_nxt[g];
                        ret_q.push_back(m_nxt[g]);
                    end
                end
                m_cnt[g] <= m_cnt[g] - 1;
            end else if (en_w[g] && m_rdy[g] && !m_stuck[g]) begin
                m_rdy[g] <= 1'b0;
                m_cnt[g] <= m_lat[g];
                m_rd[g]  <= rw_w[g];
                m_nxt[g] <= 8'($urandom);
                log_q.push_back(rw_w[g] ? 9'h100 : {1'b0, din_w[g]});
            end
        end
    end

    int cyc = 0;
    int nval0 = 0, nval1 = 0;
    logic pb0 = 1'b0;
    int rise_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sv0) nval0 <= nval0 + 1;
        if (sv1) nval1 <= nval1 + 1;
        if (busy0 && !pb0) rise_q.push_back(cyc);
        pb0 <= busy0;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp_sample(input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            if (k < ret_q.size()) v[8*k +: 8] = ret_q[k];
        end
        return v;
    endfunction

    task automatic chk_ptrs(input logic [7:0] base, input int n, input int reps);
        chk("n_xact", log_q.size(), 2 * n * reps);
        for (int k = 0; k < n * reps && 2 * k + 1 < log_q.size(); k++) begin
            chk("wr_ptr", log_q[2*k], {1'b0, 8'(base + 8'(k % n))});
            chk("rd_op", log_q[2*k+1], 9'h100);
        end
    endtask

    task automatic chk_rst0(input string p);
        chk({p, "_en"}, bus0.i2c_enable, 0);
        chk({p, "_rw"}, bus0.i2c_rw, 0);
        chk({p, "_din"}, bus0.i2c_data_in, 0);
        chk({p, "_sd"}, sd0, 0);
        chk({p, "_sv"}, sv0, 0);
        chk({p, "_busy"}, busy0, 0);
        chk({p, "_err"}, err0, 0);
        chk({p, "_ovr"}, ovr0, 0);
    endtask

    task automatic run_seq(input int d, input int lat);
        int n0, nb;
        m_lat[d] = lat;
        log_q.delete();
        ret_q.delete();
        n0 = d ? nval1 : nval0;
        nb = d ? 3 : 6;
        tick(1);
        if (d == 1) start1 = 1'b1; else start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ((d ? nval1 : nval0) != n0) break;
        end
        tick(3);
        chk("valid_cnt", (d ? nval1 : nval0) - n0, 1);
        chk("ret_bytes", ret_q.size(), nb);
        chk("sample", d ? 64'(sd1) : 64'(sd0), exp_sample(nb));
        chk_ptrs(d ? 8'hFE : 8'h01, nb, 1);
        chk("seq_err", d ? err1 : err0, 0);
        chk("seq_ovr", d ? ovr1 : ovr0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        logic [47:0] last;
        int t0, el, r0, n0, nr;

        m_lat[0] = 2;
        m_lat[1] = 2;
        m_stuck  = 2'b00;

        tick(3);
        rst = 1'b0;
        tick(1);
        chk_rst0("rst");
        chk("rst_sd1", sd1, 0);
        chk("rst_busy1", busy1, 0);
        chk("addr0", bus0.i2c_addr, 7'h1D);
        chk("addr1", bus1.i2c_addr, 7'h1D);

        for (int i = 0; i < 3; i++) run_seq(0, int'($urandom_range(1, 4)));
        for (int i = 0; i < 2; i++) run_seq(1, int'($urandom_range(1, 4)));

        // controller that never acknowledges
        m_stuck[0] = 1'b1;
        last = sd0;
        tick(1);
        start0 = 1'b1;
        t0 = cyc + 1;
        tick(1);
        start0 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (err0) break;
            tick(1);
        end
        el = cyc - t0;
        chk("tmo_err", err0, 1);
        chk("tmo_time", (el >= TO && el <= TO + 1) ? 1 : 0, 1);
        chk("tmo_en", bus0.i2c_enable, 0);
        tick(1);
        chk("tmo_busy", busy0, 0);
        chk("tmo_sticky", err0, 1);
        chk("tmo_sd", sd0, last);
        m_stuck[0] = 1'b0;
        run_seq(0, 1);

        // periodic triggering with a fast controller
        m_lat[0] = 1;
        log_q.delete();
        ret_q.delete();
        r0 = rise_q.size();
        n0 = nval0;
        tick(1);
        auto0 = 1'b1;
        tick(5 * PER + 50);
        auto0 = 1'b0;
        tick(300);
        nr = rise_q.size() - r0;
        chk("auto_nseq", nr, 5);
        for (int k = r0 + 1; k < rise_q.size(); k++) begin
            chk("auto_gap", rise_q[k] - rise_q[k-1], PER);
        end
        chk("auto_nval", nval0 - n0, 5);
        chk_ptrs(8'h01, 6, 5);
        chk("auto_ovr", ovr0, 0);

        // periodic triggering with a slow controller
        m_lat[0] = 30;
        tick(1);
        auto0 = 1'b1;
        tick(PER * 3 + 50);
        chk("slow_ovr", ovr0, 1);
        chk("slow_err", err0, 0);
        auto0 = 1'b0;
        tick(1000);
        chk("slow_ovr_sticky", ovr0, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_rst0("rst2");

        // start and period tick on the same edge
        m_lat[0] = 1;
        r0 = rise_q.size();
        n0 = nval0;
        tick(1);
        auto0 = 1'b1;
        tick(PER - 1);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        auto0 = 1'b0;
        tick(300);
        chk("same_nseq", rise_q.size() - r0, 1);
        chk("same_nval", nval0 - n0, 1);
        chk("same_ovr", ovr0, 0);

        // reset while waiting on the third read
        m_lat[0] = 10;
        log_q.delete();
        n0 = nval0;
        tick(1);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (log_q.size() >= 6) break;
            tick(1);
        end
        chk("mid_reached", log_q.size(), 6);
        tick(2);
        chk("mid_busy", busy0, 1);
        rst = 1'b1;
        tick(1);
        chk_rst0("mid");
        rst = 1'b0;
        tick(200);
        chk("mid_noval", nval0 - n0, 0);
        chk("mid_idle", busy0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
